seq_multiplier: RTL and testbench

Multi-cycle 32×32 shift-and-add multiplier for the unpipelined MIPS datapath's `mult`/`multu` instructions. It consumes the adder stage directly: every iteration adds the multiplicand into the running partial product through a 32-bit adder built from the team's 4-bit ripple slices. The 64-bit result is delivered to the HI/LO registers. The control unit stalls the pipeline while `busy` is high.

---
 rtl/mult_pkg.sv | 12 +
 rtl/adder32.sv | 25 ++
 rtl/ripple4.sv | 21 ++
 rtl/seq_multiplier.sv | 105 ++++++++++
 tb/tb_seq_multiplier.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared constants for the sequential multiplier: FSM state codes and cycle counts.
package mult_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int MULT_ITERS   = 32;
    localparam int MULT_LATENCY = 34;

endpackage

// File: rtl/adder32.sv
// 32-bit adder made of eight chained 4-bit ripple slices, carry-in tied to zero.
module adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] s,
    output logic        cout
);

    logic [8:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < 8; i++) begin : g_slice
        ripple4 u_slice (
            .a    (a[4*i +: 4]),
            .b    (b[4*i +: 4]),
            .cin  (c[i]),
            .s    (s[4*i +: 4]),
            .cout (c[i+1])
        );
    end

    assign cout = c[8];

endmodule

// File: rtl/ripple4.sv
// 4-bit ripple-carry adder slice, the building block of adder32.
module ripple4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-and-add multiplier for mult/multu; sign handled by
// multiplying magnitudes and negating the 64-bit product at the end.
import mult_pkg::*;

module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    // Handshake: start is a request honoured only while busy is low (IDLE);
    // there is no back-pressure on the result, done is a single-cycle strobe
    // and hi/lo stay stable until the next accepted request.

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]      LAST    = CW'(MULT_ITERS - 1);
    localparam logic [CW-1:0]      CNT_ONE = CW'(1);
    localparam logic [WIDTH-1:0]   ONE_W   = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_P   = (2*WIDTH)'(1);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               neg;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] p;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum_s;
    logic               sum_c;
    logic [2*WIDTH-1:0] p_fix;

    // 0x80000000 negates to itself, which is its correct unsigned magnitude.
    assign a_mag  = (is_signed && A[WIDTH-1]) ? (~A + ONE_W) : A;
    assign b_mag  = (is_signed && B[WIDTH-1]) ? (~B + ONE_W) : B;
    assign addend = p[0] ? mcand : '0;
    assign p_fix  = neg ? (~p + ONE_P) : p;

    adder32 u_add (
        .a    (p[2*WIDTH-1:WIDTH]),
        .b    (addend),
        .s    (sum_s),
        .cout (sum_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            neg   <= 1'b0;
            mcand <= '0;
            p     <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand <= a_mag;
                        p     <= {{WIDTH{1'b0}}, b_mag};
                        neg   <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        cnt   <= '0;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    // Carry out of the add becomes the new top bit of the shifted product.
                    p   <= {sum_c, sum_s, p[WIDTH-1:1]};
                    cnt <= cnt + CNT_ONE;
                    if (cnt == LAST) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    p     <= p_fix;
                    hi    <= p_fix[2*WIDTH-1:WIDTH];
                    lo    <= p_fix[WIDTH-1:0];
                    state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: vector table plus hand-built
// sequences for ignored starts and mid-operation reset.
module tb_seq_multiplier;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[14];

    seq_multiplier #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one request, optionally injecting extra start pulses at cycle
    // offsets inj1/inj2, or asserting reset at offset rst_at (then aborting).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input int inj1, input int inj2,
                          input int rst_at);
        int lat;
        int busy_cnt;
        int done_cnt;
        bit stop;
        logic [63:0] got;
        lat = -1;
        busy_cnt = 0;
        done_cnt = 0;
        stop = 1'b0;
        @(negedge clk);
        start = 1'b1;
        A = a;
        B = b;
        is_signed = s;
        @(posedge clk);
        if (rst_at < 0) exp_q.push_back(exp);
        for (int k = 1; k <= 40 && !stop; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat < 0) lat = k;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'(k), 64'(0));
                end else begin
                    got = exp_q.pop_front();
                    chk("result", {hi, lo}, got);
                end
            end
            if (rst_at >= 0 && k == rst_at + 1) begin
                chk("rst_busy", 64'(busy), 64'(0));
                chk("rst_done", 64'(done_cnt), 64'(0));
                chk("rst_hilo", {hi, lo}, 64'(0));
                chk("rst_state", 64'(dbg_state), 64'(0));
                reset = 1'b0;
                stop = 1'b1;
            end
            start = 1'b0;
            if (k == 1) begin
                A = $urandom();
                B = $urandom();
                is_signed = 1'($urandom_range(0, 1));
            end
            if (k == rst_at) reset = 1'b1;
            if (k == inj1 || k == inj2) begin
                start = 1'b1;
                A = 32'd9;
                B = 32'd9;
                is_signed = 1'b0;
            end
        end
        if (rst_at < 0) begin
            chk("latency", 64'(lat), 64'(34));
            chk("busy_cycles", 64'(busy_cnt), 64'(34));
            chk("done_pulses", 64'(done_cnt), 64'(1));
            chk("hold_hilo", {hi, lo}, exp);
            if (exp_q.size() != 0) begin
                chk("missing_done", 64'(exp_q.size()), 64'(0));
                exp_q.delete();
            end
        end
    endtask

    initial begin
        start = 1'b0;
        is_signed = 1'b0;
        A = '0;
        B = '0;
        reset = 1'b1;

        vecs[0]  = '{32'd3,        32'd5,        1'b0, 64'h00000000_0000000F};
        vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001};
        vecs[2]  = '{32'hFFFFFFF9, 32'd3,        1'b1, 64'hFFFFFFFF_FFFFFFEB};
        vecs[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001};
        vecs[4]  = '{32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000};
        vecs[5]  = '{32'h80000000, 32'h80000000, 1'b0, 64'h40000000_00000000};
        vecs[6]  = '{32'h80000000, 32'd1,        1'b1, 64'hFFFFFFFF_80000000};
        vecs[7]  = '{32'd0,        32'hFFFFFFFF, 1'b1, 64'h00000000_00000000};
        vecs[8]  = '{32'd1,        32'hFFFFFFFF, 1'b1, 64'hFFFFFFFF_FFFFFFFF};
        vecs[9]  = '{32'h00010000, 32'h00010000, 1'b0, 64'h00000001_00000000};
        for (int i = 10; i < 14; i++) begin
            vecs[i].a = $urandom();
            vecs[i].b = $urandom();
            vecs[i].s = 1'(i % 2);
            vecs[i].exp = model(vecs[i].a, vecs[i].b, vecs[i].s);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_hilo", {hi, lo}, 64'(0));
        chk("reset_state", 64'(dbg_state), 64'(0));
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, -1, -1, -1);
        end

        // starts during CALC and during DONE must be ignored
        run_op(32'd3, 32'd5, 1'b0, 64'd15, 10, 34, -1);

        // reset mid-CALC, then a fresh operation
        run_op(32'hFFFFFFFF, 32'd2, 1'b0, 64'd0, -1, -1, 12);
        run_op(32'd3, 32'd5, 1'b0, 64'd15, -1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
